ififo_skew: RTL and testbench

IFIFO_SKEW -- requirements
Module: ififo_skew

---
 rtl/ififo_skew_pkg.sv | 16 +
 rtl/ififo_skew_if.sv | 38 +++
 rtl/ififo_skew_delay.sv | 41 ++++
 rtl/ififo_skew.sv | 129 ++++++++++++
 tb/tb_ififo_skew.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ififo_skew_pkg.sv
// Shared constants and helpers for the skewed input FIFO.
// Pointer width function, lane width and output-mode encoding.
package ififo_pkg;

  localparam int BW = 4;

  typedef enum logic {
    FLAT = 1'b0,
    SKEW = 1'b1
  } mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ififo_skew_if.sv
// Write/read/status bundle of the skewed input FIFO.
// master drives requests, slave is the FIFO.
interface ififo_skew_if
  import ififo_pkg::*;
#(
  parameter int BW    = 4,
  parameter int ROW   = 8,
  parameter int DEPTH = 16
);

  localparam int CW = ptr_w(DEPTH);

  logic [BW*ROW-1:0] in;
  logic              wr;
  logic              rd;
  logic              skew_en;
  logic [BW*ROW-1:0] out;
  logic [ROW-1:0]    o_valid;
  logic              o_ready;
  logic              o_full;
  logic              o_afull;
  logic [CW-1:0]     o_count;
  logic              o_ovf;
  logic              o_unf;

  modport master (
    output in, wr, rd, skew_en,
    input  out, o_valid, o_ready, o_full,
    input  o_afull, o_count, o_ovf, o_unf
  );

  modport slave (
    input  in, wr, rd, skew_en,
    output out, o_valid, o_ready, o_full,
    output o_afull, o_count, o_ovf, o_unf
  );

endinterface

// File: rtl/ififo_skew_delay.sv
// Fixed-length lane delay carrying data and valid.
// Invalid slots always hold zero data.
module skew_delay_line #(
  parameter int BW  = 4,
  parameter int LEN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic [BW-1:0] d_i,
  input  logic          v_i,
  output logic [BW-1:0] d_o,
  output logic          v_o
);

  logic [BW-1:0]  dat_q [LEN];
  logic [LEN-1:0] vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LEN; i++)
        dat_q[i] <= '0;
      vld_q <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < LEN; i++)
        dat_q[i] <= '0;
      vld_q <= '0;
    end else begin
      dat_q[0] <= v_i ? d_i : '0;
      vld_q[0] <= v_i;
      for (int i = 1; i < LEN; i++) begin
        dat_q[i] <= dat_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign d_o = dat_q[LEN-1];
  assign v_o = vld_q[LEN-1];

endmodule

// File: rtl/ififo_skew.sv
// FWFT FIFO with optional systolic (per-lane staggered) output.
// Lane r is delayed r cycles after the pop in skew mode.
module ififo_skew #(
  parameter int BW       = 4,
  parameter int ROW      = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic        clk,
  input  logic        reset,
  ififo_skew_if.slave bus
);

  import ififo_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int WW = BW * ROW;

  logic [WW-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, unf_q;
  mode_e         mode_q;

  logic          wr_acc, rd_acc;
  logic [WW-1:0] head;

  assign wr_acc = bus.wr && !full_q;
  assign rd_acc = bus.rd && ready_q;
  assign head   = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d  = wptr_q + {{AW{1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{AW{1'b0}}, rd_acc};
    count_d = wptr_d - rptr_d;
    ready_d = wptr_d != rptr_d;
    full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0])
           && (wptr_d[AW] != rptr_d[AW]);
    afull_d = int'(count_d) >= AF_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr_q[AW-1:0]] <= bus.in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      full_q  <= 1'b0;
      afull_q <= (AF_LEVEL == 0);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mode_q  <= FLAT;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ready_q <= ready_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_q | (bus.wr && full_q);
      unf_q   <= unf_q | (bus.rd && !ready_q);
      mode_q  <= bus.skew_en ? SKEW : FLAT;
    end
  end

  // Lane 0 is never delayed, so chains exist only for lanes 1..ROW-1.
  logic [BW-1:0] ch_d [1:ROW-1];
  logic          ch_v [1:ROW-1];

  for (genvar r = 1; r < ROW; r++) begin : g_lane
    skew_delay_line #(
      .BW (BW),
      .LEN(r)
    ) u_dl (
      .clk  (clk),
      .reset(reset),
      .clr_i(!bus.skew_en),
      .d_i  (head[r*BW +: BW]),
      .v_i  (rd_acc && bus.skew_en),
      .d_o  (ch_d[r]),
      .v_o  (ch_v[r])
    );
  end

  logic [WW-1:0]  out_c;
  logic [ROW-1:0] vld_c;

  always_comb begin
    out_c = '0;
    vld_c = '0;
    unique case (1'b1)
      (mode_q == FLAT): begin
        if (ready_q)
          out_c = head;
        vld_c = {ROW{ready_q}};
      end
      default: begin
        if (ready_q)
          out_c[BW-1:0] = head[BW-1:0];
        vld_c[0] = ready_q;
        for (int r = 1; r < ROW; r++) begin
          out_c[r*BW +: BW] = ch_d[r];
          vld_c[r]          = ch_v[r];
        end
      end
    endcase
  end

  assign bus.out     = out_c;
  assign bus.o_valid = vld_c;
  assign bus.o_ready = ready_q;
  assign bus.o_full  = full_q;
  assign bus.o_afull = afull_q;
  assign bus.o_count = count_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_unf   = unf_q;

endmodule

// File: tb/tb_ififo_skew.sv
// Directed bench: fill/drain, overflow, wr+rd, skew, reset, wrap.
// Two instances: DEPTH=16 (main) and DEPTH=4 (wrap/afull).
module tb_ififo_skew;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ififo_skew_if #(.BW(4), .ROW(8), .DEPTH(16)) ia ();
  ififo_skew_if #(.BW(4), .ROW(8), .DEPTH(4))  ib ();

  ififo_skew #(
    .BW(4), .ROW(8), .DEPTH(16), .AF_LEVEL(14)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ia)
  );

  ififo_skew #(
    .BW(4), .ROW(8), .DEPTH(4), .AF_LEVEL(2)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ib)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q [$];
  logic [31:0] w;
  logic [3:0]  n;
  logic [31:0] nxt;

  initial begin
    ia.in = '0; ia.wr = 0; ia.rd = 0; ia.skew_en = 0;
    ib.in = '0; ib.wr = 0; ib.rd = 0; ib.skew_en = 0;
    #1 reset = 1'b1;
    #2;
    chk("rst_count", ia.o_count, 0);
    chk("rst_ready", ia.o_ready, 0);
    chk("rst_full",  ia.o_full,  0);
    chk("rst_afull", ia.o_afull, 0);
    chk("rst_out",   ia.out,     0);
    chk("rst_valid", ia.o_valid, 0);
    chk("rst_ovf",   ia.o_ovf,   0);
    chk("rst_unf",   ia.o_unf,   0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // fill 16 words, lane value = index
    for (int i = 0; i < 16; i++) begin
      n = i[3:0];
      ia.in = {8{n}};
      ia.wr = 1;
      tick();
      if (i == 14) begin
        chk("fill15_count", ia.o_count, 15);
        chk("fill15_full",  ia.o_full,  0);
        chk("fill15_afull", ia.o_afull, 1);
      end
    end
    chk("fill_count", ia.o_count, 16);
    chk("fill_full",  ia.o_full,  1);
    chk("fill_head",  ia.out, 32'h0000_0000);
    chk("fill_valid", ia.o_valid, 8'hFF);

    // overflow attempt
    ia.in = 32'hDEAD_BEEF;
    tick();
    ia.wr = 0;
    chk("ovf_flag",  ia.o_ovf,   1);
    chk("ovf_count", ia.o_count, 16);
    chk("ovf_head",  ia.out, 32'h0000_0000);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      n = i[3:0];
      chk("drain_data", ia.out, {8{n}});
      ia.rd = 1;
      tick();
    end
    ia.rd = 0;
    chk("drain_ready", ia.o_ready, 0);
    chk("drain_out",   ia.out,     0);
    chk("drain_valid", ia.o_valid, 0);
    chk("drain_count", ia.o_count, 0);
    chk("drain_unf",   ia.o_unf,   0);

    // simultaneous wr/rd at count 5
    for (int k = 0; k < 5; k++) begin
      w = 32'hA000_0000 + k;
      ia.in = w;
      ia.wr = 1;
      q.push_back(w);
      tick();
    end
    chk("sim_pre_count", ia.o_count, 5);
    for (int j = 0; j < 10; j++) begin
      w = 32'hA000_0005 + j;
      ia.in = w;
      ia.rd = 1;
      chk("sim_data", ia.out, q[0]);
      tick();
      void'(q.pop_front());
      q.push_back(w);
      chk("sim_count", ia.o_count, 5);
    end
    ia.wr = 0;
    for (int j = 0; j < 5; j++) begin
      chk("sim_drain", ia.out, q.pop_front());
      tick();
    end
    ia.rd = 0;
    chk("sim_empty", ia.o_count, 0);

    // wr+rd on empty: write only, read flagged
    ia.in = 32'h5555_5555;
    ia.wr = 1;
    ia.rd = 1;
    tick();
    ia.wr = 0;
    ia.rd = 0;
    chk("emp_count", ia.o_count, 1);
    chk("emp_unf",   ia.o_unf,   1);
    chk("emp_data",  ia.out, 32'h5555_5555);
    ia.rd = 1;
    tick();
    ia.rd = 0;
    chk("emp_after", ia.o_count, 0);

    // skew: single pop of 0x76543210
    ia.skew_en = 1;
    tick();
    ia.in = 32'h7654_3210;
    ia.wr = 1;
    tick();
    ia.wr = 0;
    chk("skw_pre_valid", ia.o_valid, 8'h01);
    chk("skw_pre_out",   ia.out,     32'h0);
    ia.rd = 1;
    tick();
    ia.rd = 0;
    for (int r = 1; r < 8; r++) begin
      chk("skw_valid", ia.o_valid, 64'(1) << r);
      chk("skw_out",   ia.out, 64'(r) << (4 * r));
      tick();
    end
    chk("skw_post_valid", ia.o_valid, 0);
    chk("skw_post_out",   ia.out,     0);

    // reset mid-stream with chains loaded
    for (int k = 0; k < 12; k++) begin
      ia.in = k * 32'h1111_1111;
      ia.wr = 1;
      tick();
    end
    ia.wr = 0;
    ia.rd = 1;
    for (int k = 0; k < 8; k++)
      tick();
    ia.rd = 0;
    chk("mid_valid", ia.o_valid, 8'hFF);
    chk("mid_out",   ia.out, 32'h1234_5678);
    chk("mid_count", ia.o_count, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", ia.o_valid, 0);
    chk("arst_out",   ia.out,     0);
    chk("arst_count", ia.o_count, 0);
    chk("arst_ready", ia.o_ready, 0);
    chk("arst_unf",   ia.o_unf,   0);
    @(negedge clk);
    reset = 1'b0;
    ia.skew_en = 0;
    tick();

    // DEPTH=4 wrap with afull at 2
    q.delete();
    for (int k = 0; k < 2; k++) begin
      w = 32'hB000_0000 + k;
      ib.in = w;
      ib.wr = 1;
      q.push_back(w);
      tick();
      chk("wrp_fill_afull", ib.o_afull, k == 1);
    end
    nxt = 32'hB000_0002;
    for (int j = 0; j < 40; j++) begin
      ib.in = nxt;
      ib.rd = 1;
      chk("wrp_data", ib.out, q[0]);
      tick();
      void'(q.pop_front());
      q.push_back(nxt);
      nxt++;
      chk("wrp_count", ib.o_count, 2);
      chk("wrp_afull", ib.o_afull, 1);
    end
    ib.wr = 0;
    chk("wrp_d0", ib.out, q.pop_front());
    tick();
    chk("wrp_d0_afull", ib.o_afull, 0);
    chk("wrp_d1", ib.out, q.pop_front());
    tick();
    ib.rd = 0;
    chk("wrp_end_ready", ib.o_ready, 0);
    chk("wrp_end_ovf",   ib.o_ovf,   0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
